// File: rtl/serial_adder_16bit.sv
// Nibble-serial adder: one 4-bit ripple add per clock, LSB nibble first.
// The carry is registered between nibbles; the result is published on DONE entry.

module full_adder_4_bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] c;

  assign c[0] = c_i;

  // Plain ripple chain, one full-adder cell per bit.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i])
                    | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = c[4];

endmodule

module serial_adder_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       nib_s;
  logic             nib_c;

  full_adder_4_bit u_fa (
    .a_i (a_q[3:0]),
    .b_i (b_q[3:0]),
    .c_i (cy_q),
    .s_o (nib_s),
    .c_o (nib_c)
  );

  // State and datapath registers; reset discards any in-flight add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: accept in IDLE/DONE, shift one nibble per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          cy_d    = c_in;
          cnt_d   = '0;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
        end
      end
      RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        cy_d  = nib_c;
        cnt_d = cnt_q + CW'(1);
        res_d = {nib_s, res_q[WIDTH-1:4]};
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = res_d;
          cout_d  = nib_c;
          ovf_d   = (amsb_q == bmsb_q)
                 && (res_d[WIDTH-1] != amsb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign c_out    = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_16bit.sv
// Bench for serial_adder_16bit at WIDTH=16 and WIDTH=8.
// Directed table, corner sequences, then random ops against an arithmetic model.

module tb_serial_adder_16bit;

  logic        clk = 1'b0;
  logic        rst;

  logic        start16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic        start8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_16bit #(.WIDTH(16)) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .start    (start16),
    .a        (a16),
    .b        (b16),
    .c_in     (cin16),
    .busy     (busy16),
    .done     (done16),
    .sum      (sum16),
    .c_out    (cout16),
    .overflow (ovf16)
  );

  serial_adder_16bit #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .c_in     (cin8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .c_out    (cout8),
    .overflow (ovf8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer sum, signed range test for overflow.
  task automatic model(input int w, input logic [15:0] av, bv,
                       input logic cv, output logic [15:0] es,
                       output logic ec, output logic eo);
    longint m, ua, ub, t, sa, sb, st;
    m  = (64'sd1 <<< w) - 1;
    ua = longint'(av) & m;
    ub = longint'(bv) & m;
    t  = ua + ub + longint'(cv);
    es = 16'(t & m);
    ec = ((t >> w) & 1) != 0;
    sa = (ua >= (64'sd1 <<< (w - 1))) ? ua - (m + 1) : ua;
    sb = (ub >= (64'sd1 <<< (w - 1))) ? ub - (m + 1) : ub;
    st = sa + sb + longint'(cv);
    eo = (st > ((64'sd1 <<< (w - 1)) - 1))
      || (st < -(64'sd1 <<< (w - 1)));
  endtask

  task automatic set_in(input int w, input logic s,
                        input logic [15:0] av, bv, input logic cv);
    if (w == 16) begin
      start16 = s; a16 = av; b16 = bv; cin16 = cv;
    end else begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv;
    end
  endtask

  function automatic logic g_done(input int w);
    return (w == 16) ? done16 : done8;
  endfunction

  function automatic logic g_busy(input int w);
    return (w == 16) ? busy16 : busy8;
  endfunction

  function automatic logic [15:0] g_sum(input int w);
    return (w == 16) ? sum16 : {8'h00, sum8};
  endfunction

  function automatic logic g_co(input int w);
    return (w == 16) ? cout16 : cout8;
  endfunction

  function automatic logic g_ov(input int w);
    return (w == 16) ? ovf16 : ovf8;
  endfunction

  // Called at a negedge; returns at a negedge after done has dropped.
  task automatic run_op(input int w, input logic [15:0] av, bv,
                        input logic cv, input string nm);
    logic [15:0] es;
    logic        ec, eo;
    int          n, bc;
    model(w, av, bv, cv, es, ec, eo);
    set_in(w, 1'b1, av, bv, cv);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    n  = 0;
    bc = 0;
    while (!g_done(w) && n < 20) begin
      if (g_busy(w)) bc++;
      @(negedge clk);
      n++;
    end
    chk({nm, ".lat"}, n, w / 4);
    chk({nm, ".busy"}, bc, w / 4);
    chk({nm, ".sum"}, g_sum(w), es);
    chk({nm, ".cout"}, g_co(w), ec);
    chk({nm, ".ovf"}, g_ov(w), eo);
    @(negedge clk);
    chk({nm, ".done1"}, {g_done(w), g_busy(w)}, 2'b00);
  endtask

  initial begin
    int n;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'h0009, 16'h0006, 1'b1, 16'h0010, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1;
    set_in(16, 1'b0, 16'h0, 16'h0, 1'b0);
    set_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    chk("rst.state", {busy16, done16, cout16, ovf16}, 4'h0);
    chk("rst.sum", sum16, 16'h0000);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Directed table; run_op also checks against the model,
    // the table pins the documented answers.
    for (int i = 0; i < 5; i++) begin
      run_op(16, vecs[i].a, vecs[i].b, vecs[i].cin, "vec");
      chk("vec.tsum", sum16, vecs[i].s);
      chk("vec.tco", cout16, vecs[i].co);
      chk("vec.tov", ovf16, vecs[i].ov);
    end

    // start re-pulsed during RUN must be ignored
    set_in(16, 1'b1, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(16, 1'b1, 16'hAAAA, 16'hAAAA, 1'b1);
    @(negedge clk);
    set_in(16, 1'b0, 16'h0, 16'h0, 1'b0);
    n = 1;
    while (!done16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign.lat", n, 4);
    chk("ign.sum", sum16, 16'h3333);

    // start held in DONE: straight back into RUN
    set_in(16, 1'b1, 16'h0101, 16'h0202, 1'b0);
    @(negedge clk);
    set_in(16, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("b2b.run", {busy16, done16}, 2'b10);
    chk("b2b.hold", sum16, 16'h3333);
    n = 1;
    while (!done16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.lat", n, 5);
    chk("b2b.sum", sum16, 16'h0303);
    chk("b2b.co", {cout16, ovf16}, 2'b00);
    @(negedge clk);

    // async reset after 2 RUN cycles
    set_in(16, 1'b1, 16'h1357, 16'h2468, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(16, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst.ctl", {busy16, done16, cout16, ovf16}, 4'h0);
    chk("arst.sum", sum16, 16'h0000);
    @(negedge clk);
    chk("arst.hold", {busy16, done16}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    run_op(16, 16'h0F0F, 16'h00F1, 1'b0, "post");
    chk("post.sum", sum16, 16'h1000);
    chk("post.co", cout16, 1'b0);

    for (int i = 0; i < 1000; i++)
      run_op(16, 16'($urandom), 16'($urandom), 1'($urandom), "r16");
    for (int i = 0; i < 1000; i++)
      run_op(8, 16'($urandom), 16'($urandom), 1'($urandom), "r8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
